// File: rtl/truth_table_prober.sv
// truth_table_prober: drives all 8 input rows into a 3-input netlist, captures its truth-table code and compares it with an expected code.
// Ports: clk/rst (sync, active-high); start/expected request a sweep; dut_out is the netlist output;
// in1..in3 drive the netlist (row = {in1,in2,in3}); busy/done/tt_valid report progress;
// tt_out/match/mismatch_mask hold the result; unstable_mask flags rows whose output moved.
// Optional: define TT_STABILITY_CHECK_EN to build the per-row stability check.
module truth_table_prober #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic       tt_valid,
    output logic [7:0] tt_out,
    output logic       match,
    output logic [7:0] mismatch_mask,
    output logic [7:0] unstable_mask
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [CNT_W-1:0] SETTLE = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       exp_q, exp_d, tt_q, tt_d, mm_q, mm_d;
    logic             valid_q, valid_d, match_q, match_d;
    logic             accept, cap, last_cap;
    logic [7:0]       row_bit;

    assign accept   = state_q == IDLE && start;
    assign cap      = state_q == HOLD && cnt_q == SETTLE;
    assign last_cap = cap && row_q == 3'd7;
    // Row 000 owns the MSB of the code.
    assign row_bit  = 8'h80 >> row_q;

    always_comb begin
        state_d = accept ? HOLD : state_q == DONE ? IDLE : last_cap ? DONE : state_q;
        row_d   = accept ? 3'd0 : cap ? row_q + 3'd1 : row_q;
        cnt_d   = (accept || cap) ? '0 : state_q == HOLD ? cnt_q + ONE : cnt_q;
        exp_d   = accept ? expected : exp_q;
        tt_d    = cap ? (dut_out ? tt_q | row_bit : tt_q & ~row_bit) : tt_q;
        valid_d = accept ? 1'b0 : last_cap ? 1'b1 : valid_q;
        // Compare against tt_d so the row-7 bit captured this edge is included.
        match_d = last_cap ? tt_d == exp_q : match_q;
        mm_d    = last_cap ? tt_d ^ exp_q : mm_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            mm_q    <= '0;
            valid_q <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            valid_q <= valid_d;
            match_q <= match_d;
        end
    end

    assign busy            = state_q == HOLD;
    assign done            = state_q == DONE;
    assign {in1, in2, in3} = busy ? row_q : 3'b000;
    assign tt_valid        = valid_q;
    assign tt_out          = tt_q;
    assign match           = match_q;
    assign mismatch_mask   = mm_q;

`ifdef TT_STABILITY_CHECK_EN
    logic       pre_q, pre_hit;
    logic [7:0] unst_q, unst_d;

    // With no settle cycles the previous sample is the previous row's capture, so row 0 has nothing to compare.
    assign pre_hit = SETTLE_CYCLES == 0 ? cap : state_q == HOLD && cnt_q == SETTLE - ONE;

    always_comb begin
        unst_d = accept ? '0
               : (cap && pre_q != dut_out && !(SETTLE_CYCLES == 0 && row_q == 3'd0)) ? unst_q | row_bit
               : unst_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= 1'b0;
            unst_q <= '0;
        end else begin
            pre_q  <= pre_hit ? dut_out : pre_q;
            unst_q <= unst_d;
        end
    end

    assign unstable_mask = unst_q;
`else
    assign unstable_mask = '0;
`endif
endmodule

// File: tb/tb_truth_table_prober.sv
// tb_truth_table_prober: directed vector bench for truth_table_prober with SETTLE_CYCLES=4 (a) and 0 (b).
module tb_truth_table_prober;
    typedef struct {
        bit         b;
        int         mode;
        logic [7:0] e;
        logic [7:0] tt;
        bit         m;
        logic [7:0] mm;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0, tog = 1'b0, sel = 1'b0;
    logic [7:0] expected = 8'h00;
    int mode = 0, n_chk = 0, n_fail = 0;

    logic dout_a, dout_b, busy_a, busy_b, done_a, done_b, val_a, val_b, m_a, m_b;
    logic [2:0] in_a, in_b;
    logic [7:0] tt_a, tt_b, mm_a, mm_b, us_a, us_b;
    logic busy_s, done_s, val_s, m_s;
    logic [2:0] in_s;
    logic [7:0] tt_s, mm_s;

    truth_table_prober #(.SETTLE_CYCLES(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(expected), .dut_out(dout_a),
        .in1(in_a[2]), .in2(in_a[1]), .in3(in_a[0]), .busy(busy_a), .done(done_a),
        .tt_valid(val_a), .tt_out(tt_a), .match(m_a), .mismatch_mask(mm_a), .unstable_mask(us_a)
    );

    truth_table_prober #(.SETTLE_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(expected), .dut_out(dout_b),
        .in1(in_b[2]), .in2(in_b[1]), .in3(in_b[0]), .busy(busy_b), .done(done_b),
        .tt_valid(val_b), .tt_out(tt_b), .match(m_b), .mismatch_mask(mm_b), .unstable_mask(us_b)
    );

    // Netlist models: 0 = 0x49 gate, 1 = constant 0, 2 = in1, 3 = toggles only on row 3, 4 = constant 1.
    function automatic logic netlist(input int m, input logic [2:0] r, input logic t);
        logic [7:0] c;
        c = m == 0 ? 8'h49 : m == 2 ? 8'h0F : m == 4 ? 8'hFF : 8'h00;
        return m == 3 ? (r == 3'd3 && t) : c[3'd7 - r];
    endfunction

    assign dout_a = netlist(mode, in_a, tog);
    assign dout_b = netlist(mode, in_b, tog);
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign val_s  = sel ? val_b : val_a;
    assign m_s    = sel ? m_b : m_a;
    assign in_s   = sel ? in_b : in_a;
    assign tt_s   = sel ? tt_b : tt_a;
    assign mm_s   = sel ? mm_b : mm_a;

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
        end
    endtask

    // Starts a sweep and watches a fixed window; rep >= 0 re-pulses start (with a different expected) mid-sweep.
    task automatic sweep(input bit b, input logic [7:0] e, input int rep,
                         output int cyc, output int busy_n, output int done_n, output bit row_ok);
        int s;
        s = b ? 1 : 5;
        sel = b;
        @(negedge clk);
        expected = e;
        start_a = !b;
        start_b = b;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        cyc = -1;
        busy_n = 0;
        done_n = 0;
        row_ok = 1'b1;
        for (int j = 0; j < 8 * s + 6; j++) begin
            if (j == rep) begin
                expected = ~e;
                start_a = !b;
                start_b = b;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            busy_n += int'(busy_s);
            if (done_s) begin
                done_n++;
                if (cyc < 0) cyc = j;
            end
            if (busy_s ? in_s != 3'(j / s) : in_s != 3'd0) row_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t v[7];
        int cyc, busy_n, done_n, dn, s;
        bit row_ok;
        v[0] = '{1'b0, 0, 8'h49, 8'h49, 1'b1, 8'h00};
        v[1] = '{1'b0, 1, 8'h49, 8'h00, 1'b0, 8'h49};
        v[2] = '{1'b0, 0, 8'h00, 8'h49, 1'b0, 8'h49};
        v[3] = '{1'b0, 2, 8'hF0, 8'h0F, 1'b0, 8'hFF};
        v[4] = '{1'b0, 4, 8'hFF, 8'hFF, 1'b1, 8'h00};
        v[5] = '{1'b1, 2, 8'h0F, 8'h0F, 1'b1, 8'h00};
        v[6] = '{1'b1, 0, 8'h49, 8'h49, 1'b1, 8'h00};

        repeat (3) @(negedge clk);
        chk("reset_a_outputs", {busy_a, done_a, val_a, m_a, in_a, tt_a, mm_a, us_a}, 0);
        chk("reset_b_outputs", {busy_b, done_b, val_b, m_b, in_b, tt_b, mm_b}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            mode = v[i].mode;
            s = v[i].b ? 1 : 5;
            sweep(v[i].b, v[i].e, -1, cyc, busy_n, done_n, row_ok);
            chk($sformatf("v%0d_done_latency", i), cyc, 8 * s);
            chk($sformatf("v%0d_busy_cycles", i), busy_n, 8 * s);
            chk($sformatf("v%0d_done_pulses", i), done_n, 1);
            chk($sformatf("v%0d_row_sequence", i), {31'd0, row_ok}, 1);
            chk($sformatf("v%0d_tt_valid", i), {31'd0, val_s}, 1);
            chk($sformatf("v%0d_tt_out", i), tt_s, v[i].tt);
            chk($sformatf("v%0d_match", i), {31'd0, m_s}, {31'd0, v[i].m});
            chk($sformatf("v%0d_mismatch_mask", i), mm_s, v[i].mm);
            if (!v[i].b) chk($sformatf("v%0d_unstable_mask", i), us_a, 0);
        end

        mode = 0;
        sweep(1'b0, 8'h49, 10, cyc, busy_n, done_n, row_ok);
        chk("restart_ignored_latency", cyc, 40);
        chk("restart_ignored_pulses", done_n, 1);
        chk("restart_ignored_tt_out", tt_a, 8'h49);
        chk("restart_ignored_match", {31'd0, m_a}, 1);

        sel = 1'b0;
        @(negedge clk);
        expected = 8'h0F;
        start_a = 1'b1;
        repeat (41) @(negedge clk);
        chk("held_start_done", {31'd0, done_a}, 1);
        @(negedge clk);
        chk("held_start_idle_gap", {busy_a, done_a}, 0);
        @(negedge clk);
        chk("held_start_rearm", {busy_a, val_a}, 2'b10);
        start_a = 1'b0;
        repeat (45) @(negedge clk);
        chk("held_start_result", {val_a, m_a, tt_a}, {2'b10, 8'h49});

        @(negedge clk);
        expected = 8'h49;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midsweep_reset_state", {busy_a, done_a, val_a, m_a, in_a, tt_a, mm_a}, 0);
        rst = 1'b0;
        dn = 0;
        for (int j = 0; j < 60; j++) begin
            dn += int'(done_a);
            @(negedge clk);
        end
        chk("midsweep_reset_no_done", dn, 0);

        mode = 3;
        sweep(1'b0, 8'h00, -1, cyc, busy_n, done_n, row_ok);
        chk("stability_done_pulses", done_n, 1);
`ifdef TT_STABILITY_CHECK_EN
        chk("stability_unstable_mask", us_a, 8'h10);
`else
        chk("stability_unstable_mask", us_a, 8'h00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
